// File: rtl/t_ff_counter.sv
// ---------------------------------------------------------------------------
// t_ff_counter
//
// Purpose:
//     Modulo-MODULUS up/down counter whose state is a bank of WIDTH
//     T flip-flops. Each rising edge, bit i of the state toggles when
//     tgl_d[i] is set. The toggle vector is derived from the value the
//     counter should hold next: Q_next = Q ^ tgl.
//     Supports clear, hold, up/down stepping with wrap, a terminal-count
//     flag and an optional parallel load.
//
// Parameters:
//     WIDTH   - counter width in bits (1..16)
//     MODULUS - count range 0..MODULUS-1 (2..2^WIDTH)
//
// Ports:
//     CLK  in   clock, all state changes on the rising edge
//     CLR  in   synchronous active-high clear, highest priority
//     T    in   count enable (1 = step, 0 = hold)
//     UP   in   direction (1 = increment, 0 = decrement)
//     LD   in   parallel-load strobe (only with TFF_CNT_LOAD_EN)
//     D    in   parallel-load value, clamped to MODULUS-1
//     Q    out  counter state
//     Qbar out  bitwise complement of Q
//     TC   out  terminal count, high when the next counting edge wraps
//
// Configuration macro:
//     TFF_CNT_LOAD_EN - when defined, LD/D load the counter.
//                       When undefined, LD and D are present but ignored.
// ---------------------------------------------------------------------------
module t_ff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             T,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] tgl_d;

    // Value one count away from the current state in the selected
    // direction. An out-of-range state (only reachable through
    // X-resolution) is pulled back to zero in either direction, and the
    // equality tests on MAX_VAL also keep the increment from overflowing
    // when MODULUS equals 2^WIDTH.
    always_comb begin
        step_d = '0;
        if (count_q > MAX_VAL) begin
            step_d = '0;
        end else if (UP) begin
            step_d = (count_q == MAX_VAL) ? '0 : count_q + ONE;
        end else begin
            step_d = (count_q == '0) ? MAX_VAL : count_q - ONE;
        end
    end

    // Choose the value the counter should hold after the next edge,
    // excluding clear: load beats counting, counting beats hold.
    always_comb begin
        target_d = count_q;
`ifdef TFF_CNT_LOAD_EN
        if (LD) begin
            target_d = (D <= MAX_VAL) ? D : MAX_VAL;
        end else if (T) begin
            target_d = step_d;
        end
`else
        if (T) begin
            target_d = step_d;
        end
`endif
    end

    // A bit toggles exactly where the current and target values differ,
    // so hold produces an all-zero toggle vector.
    always_comb begin
        tgl_d = count_q ^ target_d;
    end

`ifndef TFF_CNT_LOAD_EN
    // LD and D are kept for pin compatibility only; this sink keeps them
    // formally consumed without creating any logic that reaches an output.
    logic unusedLoad;
    assign unusedLoad = LD ^ (^D);
`endif

    // T flip-flop bank with synchronous clear taking precedence over
    // every toggle request.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            count_q <= '0;
        end else begin
            count_q <= count_q ^ tgl_d;
        end
    end

    // Outputs are combinational from the registered state and the
    // current inputs; TC is gated by T alone, not by CLR or LD.
    always_comb begin
        Q    = count_q;
        Qbar = ~count_q;
        TC   = T & (UP ? (count_q == MAX_VAL) : (count_q == '0));
    end

endmodule
